// File: rtl/bsg_manycore_store_tracker.sv
// Counts outstanding remote stores, classifies return packets, and serves fence/query requests.
// Latency: counter/flags 1 cycle; query response 1 cycle after accept; fence response 1 cycle after count_r reaches 0 in WAIT (min 2).
// Backpressure: return packets always consumed; one fence/query in flight, response held until fence_yumi_i.
module bsg_manycore_store_tracker #(
    parameter int x_cord_width_p      = 4,
    parameter int y_cord_width_p      = 4,
    parameter int data_width_p        = 32,
    parameter int cntr_width_p        = 16,
    parameter int ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [x_cord_width_p-1:0]      my_x_i,
    input  logic [y_cord_width_p-1:0]      my_y_i,
    input  logic                           store_sent_i,
    output logic                           store_stall_o,
    input  logic                           ret_v_i,
    input  logic [ret_packet_width_lp-1:0] ret_data_i,
    output logic                           ret_ready_o,
    input  logic                           fence_v_i,
    input  logic                           fence_op_i,
    output logic                           fence_ready_o,
    output logic                           fence_v_o,
    output logic [data_width_p-1:0]        fence_data_o,
    input  logic                           fence_yumi_i,
    output logic [cntr_width_p-1:0]        out_stores_o,
    output logic                           err_underflow_o,
    output logic                           err_overflow_o,
    output logic                           err_misroute_o,
    output logic                           err_unknown_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    logic [4:0]                ret_op;
    logic [y_cord_width_p-1:0] ret_y;
    logic [x_cord_width_p-1:0] ret_x;
    logic                      pkt_unknown, pkt_misroute, pkt_ack;

    assign ret_op = ret_data_i[ret_packet_width_lp-1 -: 5];
    assign ret_y  = ret_data_i[x_cord_width_p +: y_cord_width_p];
    assign ret_x  = ret_data_i[x_cord_width_p-1:0];

    assign pkt_unknown  = ret_v_i & (ret_op != 5'd0);
    assign pkt_misroute = ret_v_i & (ret_op == 5'd0) & ((ret_x != my_x_i) | (ret_y != my_y_i));
    assign pkt_ack      = ret_v_i & (ret_op == 5'd0) & (ret_x == my_x_i) & (ret_y == my_y_i);

    logic [cntr_width_p-1:0] count_r;
    logic [data_width_p-1:0] count_ext;
    logic                    underflow_r, overflow_r, misroute_r, unknown_r;
    logic                    cnt_full, cnt_zero;

    assign cnt_full  = (count_r == '1);
    assign cnt_zero  = (count_r == '0);
    assign count_ext = data_width_p'(count_r);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_r     <= '0;
            underflow_r <= 1'b0;
            overflow_r  <= 1'b0;
            misroute_r  <= 1'b0;
            unknown_r   <= 1'b0;
        end else begin
            // A store and an ack in the same cycle cancel out.
            if (store_sent_i & ~pkt_ack) begin
                if (cnt_full) overflow_r <= 1'b1;
                else          count_r    <= count_r + 1'b1;
            end else if (pkt_ack & ~store_sent_i) begin
                if (cnt_zero) underflow_r <= 1'b1;
                else          count_r     <= count_r - 1'b1;
            end
            if (pkt_unknown)  unknown_r  <= 1'b1;
            if (pkt_misroute) misroute_r <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (pkt_ack & ~store_sent_i & cnt_zero)
                $display("store_tracker: underflow, ack with no outstanding stores");
            if (store_sent_i & ~pkt_ack & cnt_full)
                $display("store_tracker: overflow, store issued at saturated count");
            if (pkt_unknown)
                $display("store_tracker: unknown return op %0d dropped", ret_op);
            if (pkt_misroute)
                $display("store_tracker: misrouted return packet x=%0d y=%0d dropped", ret_x, ret_y);
        end
    end
`endif

    state_e                  state_r;
    logic                    fence_ready_r, fence_v_r;
    logic [data_width_p-1:0] resp_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= IDLE;
            fence_ready_r <= 1'b1;
            fence_v_r     <= 1'b0;
            resp_r        <= '0;
        end else begin
            case (state_r)
                IDLE: if (fence_v_i) begin
                    fence_ready_r <= 1'b0;
                    if (fence_op_i) begin
                        state_r <= WAIT;
                    end else begin
                        // Snapshot is the count before this cycle's update.
                        resp_r    <= count_ext;
                        fence_v_r <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                WAIT: if (cnt_zero) begin
                    resp_r    <= '0;
                    fence_v_r <= 1'b1;
                    state_r   <= RESP;
                end
                RESP: if (fence_yumi_i) begin
                    fence_v_r     <= 1'b0;
                    fence_ready_r <= 1'b1;
                    state_r       <= IDLE;
                end
                default: begin
                    fence_v_r     <= 1'b0;
                    fence_ready_r <= 1'b1;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign ret_ready_o     = 1'b1;
    assign store_stall_o   = cnt_full;
    assign fence_ready_o   = fence_ready_r;
    assign fence_v_o       = fence_v_r;
    assign fence_data_o    = resp_r;
    assign out_stores_o    = count_r;
    assign err_underflow_o = underflow_r;
    assign err_overflow_o  = overflow_r;
    assign err_misroute_o  = misroute_r;
    assign err_unknown_o   = unknown_r;

endmodule

// File: tb/tb_bsg_manycore_store_tracker.sv
// Directed bench: fence/query responses go through an expected-response queue checked by a monitor.
module tb_bsg_manycore_store_tracker;

    localparam int X = 4;
    localparam int Y = 3;
    localparam int D = 32;
    localparam int C = 4;
    localparam int P = 5 + X + Y;

    localparam logic [X-1:0] MY_X = 4'd5;
    localparam logic [Y-1:0] MY_Y = 3'd2;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [X-1:0] my_x_i;
    logic [Y-1:0] my_y_i;
    logic         store_sent_i;
    logic         store_stall_o;
    logic         ret_v_i;
    logic [P-1:0] ret_data_i;
    logic         ret_ready_o;
    logic         fence_v_i;
    logic         fence_op_i;
    logic         fence_ready_o;
    logic         fence_v_o;
    logic [D-1:0] fence_data_o;
    logic         fence_yumi_i;
    logic [C-1:0] out_stores_o;
    logic         err_underflow_o, err_overflow_o, err_misroute_o, err_unknown_o;

    bsg_manycore_store_tracker #(
        .x_cord_width_p(X), .y_cord_width_p(Y), .data_width_p(D), .cntr_width_p(C)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
        .store_sent_i(store_sent_i), .store_stall_o(store_stall_o),
        .ret_v_i(ret_v_i), .ret_data_i(ret_data_i), .ret_ready_o(ret_ready_o),
        .fence_v_i(fence_v_i), .fence_op_i(fence_op_i), .fence_ready_o(fence_ready_o),
        .fence_v_o(fence_v_o), .fence_data_o(fence_data_o), .fence_yumi_i(fence_yumi_i),
        .out_stores_o(out_stores_o),
        .err_underflow_o(err_underflow_o), .err_overflow_o(err_overflow_o),
        .err_misroute_o(err_misroute_o), .err_unknown_o(err_unknown_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [D-1:0] data; int cycle; } exp_t;
    exp_t exp_q[$];

    int   tests = 0;
    int   fails = 0;
    logic yumi_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: checks each response on its first valid cycle, consumes it unless held.
    initial begin
        logic prev_v;
        exp_t e;
        prev_v       = 1'b0;
        fence_yumi_i = 1'b0;
        forever begin
            @(negedge clk_i);
            fence_yumi_i = 1'b0;
            if (fence_v_o === 1'b1 && !prev_v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", fence_data_o, e.data);
                    chk("resp_cycle", cyc, e.cycle);
                end
            end
            if (fence_v_o === 1'b1 && !yumi_hold) fence_yumi_i = 1'b1;
            prev_v = (fence_v_o === 1'b1);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic store();
        store_sent_i = 1'b1; tick(); store_sent_i = 1'b0;
    endtask

    task automatic ret(input logic [4:0] op, input logic [X-1:0] x, input logic [Y-1:0] y);
        ret_v_i = 1'b1; ret_data_i = {op, y, x}; tick(); ret_v_i = 1'b0;
    endtask

    task automatic ack();
        ret(5'd0, MY_X, MY_Y);
    endtask

    function automatic logic [3:0] flags();
        return {err_underflow_o, err_overflow_o, err_misroute_o, err_unknown_o};
    endfunction

    initial begin
        exp_t e;
        reset_i = 1'b1; my_x_i = MY_X; my_y_i = MY_Y;
        store_sent_i = 1'b0; ret_v_i = 1'b0; ret_data_i = '0;
        fence_v_i = 1'b0; fence_op_i = 1'b0;
        repeat (3) tick();
        reset_i = 1'b0;

        chk("rst_count", out_stores_o, 0);
        chk("rst_fence_v", fence_v_o, 0);
        chk("rst_fence_data", fence_data_o, 0);
        chk("rst_flags", flags(), 0);
        chk("rst_stall", store_stall_o, 0);
        chk("rst_ready", fence_ready_o, 1);
        chk("ret_ready", ret_ready_o, 1);

        for (int i = 1; i <= 3; i++) begin store(); chk("inc_count", out_stores_o, i); end
        for (int i = 2; i >= 0; i--) begin ack();   chk("dec_count", out_stores_o, i); end
        chk("clean_flags", flags(), 0);

        // Fence waits for two acks
        store(); store();
        fence_v_i = 1'b1; fence_op_i = 1'b1; tick(); fence_v_i = 1'b0;
        chk("wait_ready", fence_ready_o, 0);
        tick(); tick();
        chk("wait_no_resp", fence_v_o, 0);
        ack();
        chk("wait_one_ack", fence_v_o, 0);
        e.data = 0; e.cycle = cyc + 2; exp_q.push_back(e);
        ack();
        chk("wait_still_low", fence_v_o, 0);
        repeat (3) tick();
        chk("fence_done_ready", fence_ready_o, 1);

        // Query with a simultaneous store: snapshot is the old count
        repeat (5) store();
        e.data = 5; e.cycle = cyc + 1; exp_q.push_back(e);
        fence_v_i = 1'b1; fence_op_i = 1'b0; store_sent_i = 1'b1;
        tick();
        fence_v_i = 1'b0; store_sent_i = 1'b0;
        chk("query_count", out_stores_o, 6);
        chk("query_v", fence_v_o, 1);
        tick(); tick();
        chk("query_done_ready", fence_ready_o, 1);

        ack(); ack();
        chk("count4", out_stores_o, 4);
        store_sent_i = 1'b1; ack(); store_sent_i = 1'b0;
        chk("inc_dec_hold", out_stores_o, 4);
        repeat (4) ack();
        chk("drain", out_stores_o, 0);
        ack();
        chk("underflow_count", out_stores_o, 0);
        chk("underflow_flags", flags(), 4'b1000);
        tick(); tick();
        chk("underflow_sticky", err_underflow_o, 1);

        store();
        ret(5'b00001, MY_X, MY_Y);
        chk("unknown_count", out_stores_o, 1);
        chk("unknown_flags", flags(), 4'b1001);
        ret(5'd0, MY_X + 4'd1, MY_Y);
        chk("misroute_x_count", out_stores_o, 1);
        chk("misroute_flags", flags(), 4'b1011);
        ret(5'd0, MY_X, MY_Y + 3'd1);
        chk("misroute_y_count", out_stores_o, 1);
        ack();
        chk("ack_after_drops", out_stores_o, 0);

        // Saturation
        repeat (14) store();
        chk("stall_14", store_stall_o, 0);
        store();
        chk("stall_15", store_stall_o, 1);
        chk("count_15", out_stores_o, 15);
        store();
        chk("overflow_count", out_stores_o, 15);
        chk("overflow_flags", flags(), 4'b1111);

        // Held response, then reset during RESP
        yumi_hold = 1'b1;
        e.data = 15; e.cycle = cyc + 1; exp_q.push_back(e);
        fence_v_i = 1'b1; fence_op_i = 1'b0; tick(); fence_v_i = 1'b0;
        tick(); tick();
        chk("held_v", fence_v_o, 1);
        chk("held_data", fence_data_o, 15);
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        chk("abandon_v", fence_v_o, 0);
        chk("abandon_count", out_stores_o, 0);
        chk("abandon_flags", flags(), 0);
        chk("abandon_ready", fence_ready_o, 1);
        tick();
        yumi_hold = 1'b0;

        // Fence at zero: minimum latency of two cycles
        e.data = 0; e.cycle = cyc + 2; exp_q.push_back(e);
        fence_v_i = 1'b1; fence_op_i = 1'b1; tick(); fence_v_i = 1'b0;
        chk("min_lat_low", fence_v_o, 0);
        repeat (3) tick();

        // Ack in the accept cycle is counted before WAIT evaluates
        store();
        e.data = 0; e.cycle = cyc + 2; exp_q.push_back(e);
        fence_v_i = 1'b1; fence_op_i = 1'b1; ack(); fence_v_i = 1'b0;
        chk("same_cycle_ack_count", out_stores_o, 0);
        repeat (4) tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_store_tracker.md
# bsg_manycore_store_tracker

Tracks outstanding remote stores for one manycore tile. It consumes the return-network packets that acknowledge completed remote stores and counts stores issued by the tile's processor data port. It provides a fence/query handshake so the core can block until every issued store has been acknowledged. It sits between the return-network input of the tile and the core's data-port response mux, and replaces the ad-hoc counter inside the processor tile.

## Interface
Parameters:
- x_cord_width_p, "inv", X coordinate width
- y_cord_width_p, "inv", Y coordinate width
- data_width_p, 32, width of the fence response data
- cntr_width_p, 16, outstanding-store counter width; must be ≤ data_width_p
- ret_packet_width_lp, 5+x_cord_width_p+y_cord_width_p, return packet width: {op[4:0], y_cord, x_cord}, with x_cord in the LSBs

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- my_x_i  in  x_cord_width_p  this tile's X coordinate
- my_y_i  in  y_cord_width_p  this tile's Y coordinate
- store_sent_i  in  1  one-cycle pulse for each remote store accepted by the network (v_o & ready_i)
- store_stall_o  out  1  counter saturated; core must not issue remote stores
- ret_v_i  in  1  return packet valid
- ret_data_i  in  ret_packet_width_lp  return packet
- ret_ready_o  out  1  tied to 1; every return packet is consumed
- fence_v_i  in  1  fence or query request valid
- fence_op_i  in  1  0 = snapshot query, 1 = wait-until-zero fence
- fence_ready_o  out  1  request accepted when fence_v_i & fence_ready_o
- fence_v_o  out  1  response valid
- fence_data_o  out  data_width_p  response data: counter value, zero-extended
- fence_yumi_i  in  1  response consumed; legal only while fence_v_o is high
- out_stores_o  out  cntr_width_p  current registered counter
- err_underflow_o, err_overflow_o, err_misroute_o, err_unknown_o  out  1 each  sticky error flags

## Operation
- Classify each return packet (ret_v_i high):
  - unknown: op ≠ 0
  - misroute: op = 0 and (x,y) ≠ (my_x_i, my_y_i)
  - valid ack: all other packets
- Only a valid ack decrements the counter. Unknown and misrouted packets are dropped and set their sticky flag.
- Counter update, with inc = store_sent_i and dec = valid ack:
  - inc and dec together: hold
  - inc only: +1. At all-ones, hold and set err_overflow.
  - dec only: −1. At 0, hold at 0 and set err_underflow; simulation also prints $display.
- store_stall_o = (count_r == all-ones), combinational from the register.
- Fence FSM states are IDLE, WAIT and RESP.
  - IDLE: fence_ready_o = 1. On accept with op 0, capture count_r (the value before this cycle's update) into resp_r and go to RESP. On accept with op 1, go to WAIT.
  - WAIT: if count_r == 0, set resp_r = 0 and go to RESP; otherwise stay.
  - RESP: fence_v_o = 1 and fence_data_o = resp_r. Inputs must not change fence_data_o. On fence_yumi_i, go to IDLE.
- fence_ready_o is 0 in WAIT and RESP, so there is one request in flight at most.
- Sticky flags are cleared only by reset_i.

## Timing
- Reset: count_r = 0, state = IDLE, fence_v_o = 0, fence_data_o = 0, all error flags = 0, store_stall_o = 0, fence_ready_o = 1 in the cycle after reset deasserts. ret_ready_o = 1 at all times.
- Counter and flags update on the rising clock edge after the triggering input. out_stores_o reflects the new value one cycle later.
- Query latency: accepted in cycle t, fence_v_o high in t+1.
- Fence latency: accepted in cycle t, fence_v_o high no earlier than t+2. It rises in the cycle after the first WAIT cycle in which count_r == 0.
- An ack arriving in the same cycle a fence is accepted is counted before the WAIT evaluation.
- fence_v_o stays high until the cycle fence_yumi_i is sampled. IDLE is entered the next cycle, so back-to-back requests are separated by at least one cycle.
- fence_yumi_i in the same cycle that fence_v_o first rises completes the handshake.
- reset_i asserted in WAIT or RESP abandons the request: fence_v_o is 0 the next cycle and the counter is 0.
- The error conditions print $display in simulation only, inside the synthesis translate-off guard.

## Test plan
- Reset, then 3 store_sent_i pulses, then 3 valid acks from coordinates (my_x, my_y) → out_stores_o goes 1,2,3,2,1,0 and no error flags are set.
- count = 2; issue a fence (op 1) → fence_v_o stays low. After the 2nd ack, fence_v_o rises 1 cycle after count_r = 0, with data 0. Yumi returns to IDLE.
- count = 5; issue a query (op 0) in the same cycle as a store_sent_i pulse → response data = 5 at t+1, and out_stores_o = 6.
- Simultaneous store_sent_i and valid ack at count 4 → count stays 4. An ack at count 0 → count stays 0 and err_underflow_o = 1 until reset.
- Return packets with op = 5'b00001, and with x = my_x+1 → count unchanged, err_unknown_o = 1, err_misroute_o = 1.
- cntr_width_p = 4: 15 stores give store_stall_o = 1, and a 16th store sets err_overflow_o with count held at 15. Assert reset during RESP → fence_v_o = 0 the next cycle.
